if_fetch_unit: RTL

- Instruction-fetch stage that drives the IF/ID pipeline register: owns the 9-bit PC, issues requests to instruction memory, and buffers one returned word.
- Presents {instruction, PC} plus the IF/ID load enable, inserting NOP bubbles when no instruction is ready.
- Honours hazard stalls and branch/jump redirects from downstream stages.

---
 rtl/if_fetch_unit_pkg.sv | 13 +
 rtl/if_fetch_unit_fetch_buffer.sv | 37 +++
 rtl/if_fetch_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: PC width, bubble word, PC step and FSM states.
package if_fetch_unit_pkg;

  localparam int PC_W = 9;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [PC_W-1:0] PC_INC = 9'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// One-entry instruction buffer. Load lands at the next edge; flush beats load, load beats consume.
// Backpressure: owner must not load a full entry unless it is consumed in the same edge.
module if_fetch_unit_fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int AW = PC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_pc,
  input  logic [31:0]   load_instr,
  input  logic          consume,
  input  logic          flush,
  output logic          buf_valid,
  output logic [AW-1:0] buf_pc,
  output logic [31:0]   buf_instr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= NOP_WORD;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      // Covers load+consume in one edge: the drained slot is refilled.
      buf_valid <= 1'b1;
      buf_pc    <= load_pc;
      buf_instr <= load_instr;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns PC, requests imem, feeds IF/ID; redirect-to-target is 2 edges with zero-wait memory.
// Backpressure: stall holds IF/ID; requests only go out when the buffer is empty or draining.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int               PC_W     = if_fetch_unit_pkg::PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP_WORD = if_fetch_unit_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic            ifid_le
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            run;
  logic            accept;
  logic            consume;
  logic            buf_valid;
  logic [PC_W-1:0] buf_pc;
  logic [31:0]     buf_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d  = BOOT;
    run      = 1'b0;
    ifid_le  = 1'b0;
    imem_req = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        state_d  = RUN;
        run      = 1'b1;
        ifid_le  = !stall;
        // Never fetch into a full buffer that is not draining this cycle.
        imem_req = !redirect_valid && (!buf_valid || !stall);
      end
      default: state_d = BOOT;
    endcase
  end

  assign accept  = imem_req && imem_ready;
  assign consume = ifid_le && buf_valid;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc;
    else if (accept)
      pc_d = pc_q + PC_W'(PC_INC);
  end

  if_fetch_unit_fetch_buffer #(
    .AW(PC_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .consume    (consume),
    .flush      (redirect_valid),
    .buf_valid  (buf_valid),
    .buf_pc     (buf_pc),
    .buf_instr  (buf_instr)
  );

  assign imem_addr = pc_q;
  assign if_valid  = buf_valid;
  assign if_instr  = buf_valid ? buf_instr : NOP_WORD;
  assign if_pc     = buf_valid ? buf_pc : '0;

  logic unused_run;
  assign unused_run = run;

endmodule
